trap_collector: RTL

- Gathers exception reports from the execute/LSU writeback ports and keeps only the oldest one in program order, using robIdx_t age comparison.
- Holds that record until the ROB retires up to the excepting instruction.
- Then emits one trapInfo_t to the CSR/trap-entry unit with a valid/ready handshake.
- It is the producer end of the trapInfo_t interface. It sits between the writeback ports, the ROB commit logic and the CSR file.

---
 rtl/core_comm.sv | 46 ++++
 rtl/trap_oldest_sel.sv | 49 ++++
 rtl/trap_collector.sv | 113 +++++++++++
 3 files changed

// File: rtl/core_comm.sv
// Shared core communication package.
// Holds the ROB index type and its age comparison, the trap record sent to
// the CSR/trap-entry unit, the per-port exception bundle and the
// trap-collector state encoding.
`ifndef ROB_SIZE
`define ROB_SIZE 64
`endif

package core_comm;

    localparam int XLEN      = 64;
    localparam int ROB_SIZE  = `ROB_SIZE;
    localparam int ROB_IDX_W = $clog2(ROB_SIZE);

    // flipped toggles each time the ROB pointer wraps, so two indices can be
    // ordered across the wrap point without a full sequence number.
    typedef struct packed {
        logic                 flipped;
        logic [ROB_IDX_W-1:0] idx;
    } robIdx_t;

    typedef struct packed {
        logic [15:0]     cause;
        logic [XLEN-1:0] epc;
        logic [XLEN-1:0] tval;
    } trapInfo_t;

    typedef struct packed {
        robIdx_t         rob_idx;
        logic [15:0]     cause;
        logic [XLEN-1:0] epc;
        logic [XLEN-1:0] tval;
    } exc_bundle_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPORT = 2'd2
    } trapCollState_t;

    // True when a is strictly older than b in program order.
    function automatic logic robIdx_older(input robIdx_t a, input robIdx_t b);
        return (a.flipped == b.flipped) ? (a.idx < b.idx) : (a.idx > b.idx);
    endfunction

endpackage

// File: rtl/trap_oldest_sel.sv
// Combinational oldest-exception select.
// Ports:
//   vld        per-port exception valid
//   exc        per-port exception bundles
//   squash_vld squash active this cycle
//   squash_idx squash point; ports strictly younger than it are masked out
//   sel_vld    at least one surviving port
//   sel        bundle of the oldest surviving port (lowest port on ties)
module trap_oldest_sel
    import core_comm::*;
#(
    parameter int NUM_PORTS = 4
) (
    input  logic                        squash_vld,
    input  robIdx_t                     squash_idx,
    input  logic        [NUM_PORTS-1:0] vld,
    input  exc_bundle_t [NUM_PORTS-1:0] exc,
    output logic                        sel_vld,
    output exc_bundle_t                 sel
);

    localparam int LVLS  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 0;
    localparam int NLEAF = 1 << LVLS;

    // Heap-ordered tree: node n has children 2n and 2n+1, leaves start at NLEAF.
    logic        [2*NLEAF-1:0] nv;
    exc_bundle_t [2*NLEAF-1:0] nb;

    always_comb begin
        nv = '0;
        nb = '0;
        for (int l = 0; l < NUM_PORTS; l++) begin
            nv[NLEAF+l] = vld[l] && !(squash_vld && robIdx_older(squash_idx, exc[l].rob_idx));
            nb[NLEAF+l] = exc[l];
        end
        // Right child only wins when strictly older, so ties fall to the lower port.
        for (int n = NLEAF - 1; n >= 1; n--) begin
            if (nv[2*n+1] && (!nv[2*n] || robIdx_older(nb[2*n+1].rob_idx, nb[2*n].rob_idx)))
                nb[n] = nb[2*n+1];
            else
                nb[n] = nb[2*n];
            nv[n] = nv[2*n] | nv[2*n+1];
        end
    end

    assign sel_vld = nv[1];
    assign sel     = nb[1];

endmodule

// File: rtl/trap_collector.sv
// Trap collector: keeps the oldest reported exception, waits for the ROB to
// reach it, then hands one trapInfo_t to the CSR/trap-entry unit.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_exc_*                  per-port exception reports from writeback
//   i_squash_vld/_robIdx     kill entries strictly younger than the squash point
//   i_flush_all              drop everything, including a trap being reported
//   o_pending/_robIdx        a record is held and its ROB index
//   i_take                   ROB head reached the held record
//   o_trap_vld/_info, i_trap_rdy  trap handshake toward the CSR file
module trap_collector
    import core_comm::*;
#(
    parameter int NUM_PORTS = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic    [NUM_PORTS-1:0]         i_exc_vld,
    input  robIdx_t [NUM_PORTS-1:0]         i_exc_robIdx,
    input  logic    [NUM_PORTS-1:0][15:0]   i_exc_cause,
    input  logic    [NUM_PORTS-1:0][XLEN-1:0] i_exc_epc,
    input  logic    [NUM_PORTS-1:0][XLEN-1:0] i_exc_tval,
    input  logic                            i_squash_vld,
    input  robIdx_t                         i_squash_robIdx,
    input  logic                            i_flush_all,
    output logic                            o_pending,
    output robIdx_t                         o_pending_robIdx,
    input  logic                            i_take,
    output logic                            o_trap_vld,
    output trapInfo_t                       o_trap_info,
    input  logic                            i_trap_rdy
);

    exc_bundle_t [NUM_PORTS-1:0] exc;
    logic                        sel_vld;
    exc_bundle_t                 sel;
    trapCollState_t              state;
    exc_bundle_t                 held;
    logic                        trap_vld;
    trapInfo_t                   trap_info;
    logic                        held_killed;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign exc[p] = '{rob_idx: i_exc_robIdx[p], cause: i_exc_cause[p],
                          epc: i_exc_epc[p], tval: i_exc_tval[p]};
    end

    trap_oldest_sel #(.NUM_PORTS(NUM_PORTS)) u_sel (
        .squash_vld (i_squash_vld),
        .squash_idx (i_squash_robIdx),
        .vld        (i_exc_vld),
        .exc        (exc),
        .sel_vld    (sel_vld),
        .sel        (sel)
    );

    assign held_killed = i_squash_vld && robIdx_older(i_squash_robIdx, held.rob_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            held      <= '0;
            trap_vld  <= 1'b0;
            trap_info <= '0;
        end else if (i_flush_all) begin
            state    <= IDLE;
            trap_vld <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_vld) begin
                        held  <= sel;
                        state <= HELD;
                    end
                end
                HELD: begin
                    // A squash that kills the record still lets a surviving
                    // same-cycle report (already squash-masked) take its place.
                    if (held_killed) begin
                        if (sel_vld) held <= sel;
                        else         state <= IDLE;
                    end else if (i_take) begin
                        state     <= REPORT;
                        trap_vld  <= 1'b1;
                        trap_info <= '{cause: held.cause, epc: held.epc, tval: held.tval};
                    end else if (sel_vld && robIdx_older(sel.rob_idx, held.rob_idx)) begin
                        held <= sel;
                    end
                end
                REPORT: begin
                    if (i_trap_rdy) begin
                        state    <= IDLE;
                        trap_vld <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(i_take && state != HELD))
                else $warning("trap_collector: i_take while no record is held, ignored");
        end
    end

    assign o_pending        = (state == HELD);
    assign o_pending_robIdx = held.rob_idx;
    assign o_trap_vld       = trap_vld;
    assign o_trap_info      = trap_info;

endmodule
